// File: rtl/truth_table_checker.sv
// Exhaustive truth-table tester: steps dut_in through every vector, samples dut_out after SETTLE cycles
// and scores it against EXPECTED; a run takes 2**N_IN*(SETTLE+1) cycles, start is ignored while busy.
module truth_table_checker #(
   parameter int                          N_IN     = 3,
   parameter int                          N_OUT    = 3,
   parameter int                          SETTLE   = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0]  EXPECTED = 24'hED6530
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_OUT-1:0]  dut_out,
   output logic [N_IN-1:0]   dut_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic [N_IN-1:0]   first_fail_vec,
   output logic [N_OUT-1:0]  first_fail_out
);

   localparam int               TBL_W    = N_OUT * (2**N_IN);
   localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  VEC_LAST = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t             state_q, state_d;
   logic [N_IN-1:0]    vec_q, vec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_IN:0]      err_cnt_q, err_cnt_d;
   logic [N_IN-1:0]    ff_vec_q, ff_vec_d;
   logic [N_OUT-1:0]   ff_out_q, ff_out_d;
   logic               fail_seen_q, fail_seen_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;

   logic [TBL_W-1:0]   exp_shift;
   logic [N_OUT-1:0]   exp_out;
   logic               mismatch;

   always_comb begin
      exp_shift   = EXPECTED >> (int'(vec_q) * N_OUT);
      exp_out     = exp_shift[N_OUT-1:0];
      mismatch    = (dut_out != exp_out);

      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      ff_vec_d    = ff_vec_q;
      ff_out_d    = ff_out_q;
      fail_seen_d = fail_seen_q;

      case (state_q)
         IDLE, DONE: begin
            // DONE holds its results until a new start clears them
            if (start) begin
               err_cnt_d   = '0;
               ff_vec_d    = '0;
               ff_out_d    = '0;
               fail_seen_d = 1'b0;
               vec_d       = '0;
               cnt_d       = '0;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               err_cnt_d = err_cnt_q + (N_IN+1)'(1);
               if (!fail_seen_q) begin
                  fail_seen_d = 1'b1;
                  ff_vec_d    = vec_q;
                  ff_out_d    = dut_out;
               end
            end
            if (vec_q == VEC_LAST) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + N_IN'(1);
               cnt_d   = '0;
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         cnt_q       <= '0;
         err_cnt_q   <= '0;
         ff_vec_q    <= '0;
         ff_out_q    <= '0;
         fail_seen_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         ff_vec_q    <= ff_vec_d;
         ff_out_q    <= ff_out_d;
         fail_seen_q <= fail_seen_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign dut_in         = vec_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_fail_vec = ff_vec_q;
   assign first_fail_out = ff_out_q;

endmodule
